// File: rtl/grf_mp.sv
// Three-read / two-write register file with register 0 hardwired to zero and a
// background clear sweep. Define GRF_MP_BYPASS_EN for write-to-read forwarding.
module grf_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              o_dbg_state
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] IDX_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] IDX_LAST  = '1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              w_clr_en;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_mem [NREG];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_clr_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (clr_req) begin
                    w_next_state = S_SWEEP;
                end
            end
            S_SWEEP: begin
                w_clr_en = 1'b1;
                if (r_idx == IDX_LAST) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Index parks at 1 while idle so a new sweep always starts from register 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx <= IDX_FIRST;
        end else if (w_clr_en) begin
            r_idx <= (r_idx == IDX_LAST) ? IDX_FIRST : r_idx + IDX_FIRST;
        end else begin
            r_idx <= IDX_FIRST;
        end
    end

    // Later assignments win: clear < port 0 < port 1. Entry 0 is never written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (w_clr_en && (r_idx == ADDR_W'(i))) begin
                    r_mem[i] <= '0;
                end
                if (we0 && (waddr0 == ADDR_W'(i))) begin
                    r_mem[i] <= wdata0;
                end
                if (we1 && (waddr1 == ADDR_W'(i))) begin
                    r_mem[i] <= wdata1;
                end
            end
        end
    end

    function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        if (a == '0) begin
            v = '0;
`ifdef GRF_MP_BYPASS_EN
        end else if (we1 && (waddr1 == a)) begin
            v = wdata1;
        end else if (we0 && (waddr0 == a)) begin
            v = wdata0;
`endif
        end else begin
            v = r_mem[a];
        end
        return v;
    endfunction

    always_comb begin
        rdata0 = f_read(raddr0);
        rdata1 = f_read(raddr1);
        rdata2 = f_read(raddr2);
    end

    assign clr_busy    = (r_state == S_SWEEP);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_grf_mp.sv
// Directed scoreboard bench for grf_mp: a 32x32 instance and an 8x8 instance.
module tb_grf_mp;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Large instance (DATA_W=32, ADDR_W=5)
    logic        we0, we1, clr_req, clr_busy, dbg_state;
    logic [4:0]  waddr0, waddr1, raddr0, raddr1, raddr2;
    logic [31:0] wdata0, wdata1, rdata0, rdata1, rdata2;

    // Small instance (DATA_W=8, ADDR_W=3)
    logic        s_we0, s_we1, s_clr_req, s_clr_busy, s_dbg_state;
    logic [2:0]  s_waddr0, s_waddr1, s_raddr0, s_raddr1, s_raddr2;
    logic [7:0]  s_wdata0, s_wdata1, s_rdata0, s_rdata1, s_rdata2;

`ifdef GRF_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    grf_mp #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset),
        .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .raddr0(raddr0), .raddr1(raddr1), .raddr2(raddr2),
        .rdata0(rdata0), .rdata1(rdata1), .rdata2(rdata2),
        .clr_req(clr_req), .clr_busy(clr_busy), .o_dbg_state(dbg_state)
    );

    grf_mp #(.DATA_W(8), .ADDR_W(3)) dut_s (
        .clk(clk), .reset(reset),
        .we0(s_we0), .we1(s_we1), .waddr0(s_waddr0), .waddr1(s_waddr1),
        .wdata0(s_wdata0), .wdata1(s_wdata1),
        .raddr0(s_raddr0), .raddr1(s_raddr1), .raddr2(s_raddr2),
        .rdata0(s_rdata0), .rdata1(s_rdata1), .rdata2(s_rdata2),
        .clr_req(s_clr_req), .clr_busy(s_clr_busy), .o_dbg_state(s_dbg_state)
    );

    // Scoreboard: port ids 0-2 big rdata, 3-5 small rdata, 6 big busy, 7 small busy
    logic [31:0] exp_q[$];
    int          port_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic expect_val(input int port, input logic [31:0] v, input string nm);
        exp_q.push_back(v);
        port_q.push_back(port);
        name_q.push_back(nm);
    endtask

    task automatic rd(input int k, input logic [4:0] a, input logic [31:0] v, input string nm);
        case (k)
            0: raddr0 = a;
            1: raddr1 = a;
            default: raddr2 = a;
        endcase
        expect_val(k, v, nm);
    endtask

    task automatic srd(input int k, input logic [2:0] a, input logic [7:0] v, input string nm);
        case (k)
            0: s_raddr0 = a;
            1: s_raddr1 = a;
            default: s_raddr2 = a;
        endcase
        expect_val(3 + k, {24'b0, v}, nm);
    endtask

    // Advance to the next falling edge and drop all one-cycle strobes.
    task automatic step();
        @(negedge clk);
        we0 = 1'b0; we1 = 1'b0; clr_req = 1'b0;
        s_we0 = 1'b0; s_we1 = 1'b0; s_clr_req = 1'b0;
    endtask

    // Monitor: outputs are combinational/registered, sampled 2ns after the falling edge.
    logic [31:0] mon_act, mon_exp;
    int          mon_port;
    string       mon_name;
    always begin
        @(negedge clk);
        #2;
        while (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_port = port_q.pop_front();
            mon_name = name_q.pop_front();
            case (mon_port)
                0: mon_act = rdata0;
                1: mon_act = rdata1;
                2: mon_act = rdata2;
                3: mon_act = {24'b0, s_rdata0};
                4: mon_act = {24'b0, s_rdata1};
                5: mon_act = {24'b0, s_rdata2};
                6: mon_act = {31'b0, clr_busy};
                default: mon_act = {31'b0, s_clr_busy};
            endcase
            n_checks++;
            if (mon_act !== mon_exp) begin
                n_errors++;
                $display("FAIL %s: got %h expected %h at %0t", mon_name, mon_act, mon_exp, $time);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        we0 = 0; we1 = 0; waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0;
        raddr0 = 0; raddr1 = 0; raddr2 = 0; clr_req = 0;
        s_we0 = 0; s_we1 = 0; s_waddr0 = 0; s_waddr1 = 0; s_wdata0 = 0; s_wdata1 = 0;
        s_raddr0 = 0; s_raddr1 = 0; s_raddr2 = 0; s_clr_req = 0;

        // Reset state
        step();
        rd(0, 5'd5, 32'h0, "reset_rd");
        expect_val(6, 32'h0, "reset_busy");
        expect_val(7, 32'h0, "s_reset_busy");
        step();
        reset = 1'b1;

        // Write latency and same-cycle forwarding
        step();
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hDEADBEEF;
        rd(0, 5'd3, BYP ? 32'hDEADBEEF : 32'h0, "wr_same_cycle");
        step();
        rd(0, 5'd3, 32'hDEADBEEF, "wr_next_cycle");

        // Dual write to one index: port 1 wins; index 0 discards writes
        step();
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
        rd(1, 5'd7, BYP ? 32'h22 : 32'h0, "dual_same_cycle");
        step();
        rd(1, 5'd7, 32'h22, "dual_port1_wins");
        step();
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFF;
        rd(2, 5'd0, 32'h0, "r0_same_cycle");
        step();
        rd(2, 5'd0, 32'h0, "r0_discard");

        // Per-port bypass selection with different write targets
        step();
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h99;
        we1 = 1'b1; waddr1 = 5'd8; wdata1 = 32'h88;
        rd(0, 5'd9, BYP ? 32'h99 : 32'h0, "byp_port0");
        rd(1, 5'd8, BYP ? 32'h88 : 32'h0, "byp_port1");
        rd(2, 5'd3, 32'hDEADBEEF, "byp_none");

        // Fill 1..31 with the index, read back
        for (int i = 1; i < 32; i++) begin
            step();
            we0 = 1'b1; waddr0 = 5'(i); wdata0 = 32'(i);
        end
        for (int i = 1; i < 32; i += 3) begin
            step();
            rd(0, 5'(i), 32'(i), "fill_rd0");
            if (i + 1 < 32) rd(1, 5'(i + 1), 32'(i + 1), "fill_rd1");
            if (i + 2 < 32) rd(2, 5'(i + 2), 32'(i + 2), "fill_rd2");
        end

        // Full sweep: busy exactly 31 cycles; extra clr_req mid-sweep ignored
        step();
        clr_req = 1'b1;
        expect_val(6, 32'h0, "busy_before");
        for (int k = 1; k < 32; k++) begin
            step();
            if (k == 8) clr_req = 1'b1;
            expect_val(6, 32'h1, "busy_sweep");
            rd(0, 5'(k), 32'(k), "sweep_stored");
            if (k >= 2) rd(1, 5'(k - 1), 32'h0, "sweep_cleared");
        end
        step();
        expect_val(6, 32'h0, "busy_after");
        for (int i = 1; i < 32; i += 3) begin
            step();
            rd(0, 5'(i), 32'h0, "clr_rd0");
            if (i + 1 < 32) rd(1, 5'(i + 1), 32'h0, "clr_rd1");
            if (i + 2 < 32) rd(2, 5'(i + 2), 32'h0, "clr_rd2");
        end

        // Writes during a sweep
        step();
        clr_req = 1'b1;
        for (int k = 1; k < 32; k++) begin
            step();
            expect_val(6, 32'h1, "busy_sweep2");
            if (k == 10) begin
                we0 = 1'b1; waddr0 = 5'd5;  wdata0 = 32'hA5;
                we1 = 1'b1; waddr1 = 5'd10; wdata1 = 32'h77;
            end
            if (k == 11) begin
                we0 = 1'b1; waddr0 = 5'd20; wdata0 = 32'h5A;
            end
            if (k == 12) rd(0, 5'd20, 32'h5A, "sweep_wr_visible");
        end
        step();
        expect_val(6, 32'h0, "busy_after2");
        rd(0, 5'd5, 32'hA5, "swept_wr_persists");
        rd(1, 5'd10, 32'h77, "wr_beats_clear");
        rd(2, 5'd20, 32'h0, "unswept_wr_zeroed");

        // Reset in the middle of a sweep
        for (int i = 1; i < 32; i++) begin
            step();
            we0 = 1'b1; waddr0 = 5'(i); wdata0 = 32'(100 + i);
        end
        step();
        rd(0, 5'd25, 32'd125, "refill_rd");
        clr_req = 1'b1;
        for (int k = 1; k < 15; k++) begin
            step();
        end
        step();
        reset = 1'b0;
        expect_val(6, 32'h0, "rst_abort_busy");
        rd(0, 5'd20, 32'h0, "rst_abort_r20");
        rd(1, 5'd25, 32'h0, "rst_abort_r25");
        rd(2, 5'd31, 32'h0, "rst_abort_r31");
        step();
        we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h99; clr_req = 1'b1;
        expect_val(6, 32'h0, "rst_hold_busy");
        step();
        reset = 1'b1;
        rd(0, 5'd4, 32'h0, "rst_write_ignored");
        expect_val(6, 32'h0, "rst_no_residual");
        step();
        expect_val(6, 32'h0, "rst_no_residual2");
        rd(1, 5'd31, 32'h0, "rst_r31_after");

        // Small instance: three distinct reads, 7-cycle sweep
        for (int i = 1; i < 8; i++) begin
            step();
            s_we0 = 1'b1; s_waddr0 = 3'(i); s_wdata0 = 8'(8'h10 + i);
        end
        step();
        srd(0, 3'd1, 8'h11, "s_rd_a"); srd(1, 3'd2, 8'h12, "s_rd_b"); srd(2, 3'd3, 8'h13, "s_rd_c");
        step();
        srd(0, 3'd4, 8'h14, "s_rd_a"); srd(1, 3'd5, 8'h15, "s_rd_b"); srd(2, 3'd6, 8'h16, "s_rd_c");
        step();
        srd(0, 3'd7, 8'h17, "s_rd_a"); srd(1, 3'd0, 8'h00, "s_rd_b"); srd(2, 3'd1, 8'h11, "s_rd_c");
        step();
        s_clr_req = 1'b1;
        expect_val(7, 32'h0, "s_busy_before");
        for (int k = 1; k < 8; k++) begin
            step();
            expect_val(7, 32'h1, "s_busy_sweep");
        end
        step();
        expect_val(7, 32'h0, "s_busy_after");
        srd(0, 3'd3, 8'h00, "s_clr_a"); srd(1, 3'd5, 8'h00, "s_clr_b"); srd(2, 3'd7, 8'h00, "s_clr_c");

        step();
        step();
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
